// File: rtl/ram_line_responder_pkg.sv
// Shared definitions for the cache-to-RAM line interface: default sizes,
// FSM state encodings and the fill pattern returned for never-written lines.
package ram_line_responder_pkg;

    localparam int ADDR_SIZE_DEF  = 13;
    localparam int WORD_SIZE_DEF  = 16;
    localparam int LINE_WIDTH_DEF = 64;
    localparam int LATENCY_DEF    = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WCAPT,
        S_WACK,
        S_RWAIT,
        S_RBURST
    } state_e;

    // Beat k of an unwritten line is {addr, k[1:0]}; callers truncate to WORD_SIZE.
    function automatic logic [31:0] fill_word(input logic [29:0] addr, input logic [1:0] beat);
        return {addr, beat};
    endfunction

endpackage

// File: rtl/ram_line_store.sv
// Line-wide single-port storage: synchronous write, combinational read.
// With RAM_LINE_RESPONDER_FILL_EN a written bitmap selects stored data or the fill pattern.
module ram_line_store
    import ram_line_responder_pkg::*;
#(
    parameter int ADDR_SIZE  = ADDR_SIZE_DEF,
    parameter int WORD_SIZE  = WORD_SIZE_DEF,
    parameter int LINE_WIDTH = LINE_WIDTH_DEF
) (
    input  logic                  clk,
`ifdef RAM_LINE_RESPONDER_FILL_EN
    input  logic                  rst_n,
`endif
    input  logic [ADDR_SIZE-1:0]  addr,
    input  logic                  we,
    input  logic [LINE_WIDTH-1:0] wline,
    output logic [LINE_WIDTH-1:0] rline
);
    localparam int BEATS = LINE_WIDTH / WORD_SIZE;

    logic [LINE_WIDTH-1:0] mem [2**ADDR_SIZE];

    // NOTE: the array has no reset so it maps onto block RAM; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wline;
    end

`ifdef RAM_LINE_RESPONDER_FILL_EN
    logic [2**ADDR_SIZE-1:0] written;
    logic [LINE_WIDTH-1:0]   fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  written       <= '0;
        else if (we) written[addr] <= 1'b1;
    end

    always_comb begin
        fill = '0;
        for (int k = 0; k < BEATS; k++)
            fill[k*WORD_SIZE +: WORD_SIZE] = WORD_SIZE'(fill_word(30'(addr), 2'(k)));
        rline = written[addr] ? mem[addr] : fill;
    end
`else
    assign rline = mem[addr];
`endif

endmodule

// File: rtl/ram_line_responder.sv
// Memory-side responder for the cache line burst protocol (write collect + ack, latency-delayed read burst).
// Define RAM_LINE_RESPONDER_FILL_EN to return a deterministic pattern for never-written lines.
module ram_line_responder
    import ram_line_responder_pkg::*;
#(
    parameter int ADDR_SIZE  = ADDR_SIZE_DEF,
    parameter int WORD_SIZE  = WORD_SIZE_DEF,
    parameter int LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int LATENCY    = LATENCY_DEF
) (
    input  logic                  ram_clk,
    input  logic                  ram_rst_n,
    input  logic [ADDR_SIZE-1:0]  ram_addr,
    input  logic                  ram_avalid,
    input  logic                  ram_rnw,
    input  logic [WORD_SIZE-1:0]  ram_wdata,
    output logic [WORD_SIZE-1:0]  ram_rdata,
    output logic                  ram_ack,
    output logic [LINE_WIDTH-1:0] data_backdoor
);
    localparam int BEATS    = LINE_WIDTH / WORD_SIZE;
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int LAT_LAST = (LATENCY > 0) ? LATENCY - 1 : 0;

    state_e                state, state_d;
    logic [ADDR_SIZE-1:0]  addr_q, store_addr;
    logic [LINE_WIDTH-1:0] line_q, wr_line, rd_line;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [LAT_W-1:0]      lat_cnt;
    logic                  last_beat, lat_done, mem_we;

    // The address phase reads the array directly so a zero-latency burst has its line in time.
    assign store_addr = (state == S_IDLE) ? ram_addr : addr_q;

    ram_line_store #(
        .ADDR_SIZE (ADDR_SIZE),
        .WORD_SIZE (WORD_SIZE),
        .LINE_WIDTH(LINE_WIDTH)
    ) u_store (
        .clk  (ram_clk),
`ifdef RAM_LINE_RESPONDER_FILL_EN
        .rst_n(ram_rst_n),
`endif
        .addr (store_addr),
        .we   (mem_we),
        .wline(wr_line),
        .rline(rd_line)
    );

    always_ff @(posedge ram_clk or negedge ram_rst_n) begin
        if (!ram_rst_n) state <= S_IDLE;
        else            state <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state;
        mem_we    = 1'b0;
        last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
        lat_done  = (lat_cnt == LAT_W'(LAT_LAST));
        wr_line   = line_q;
        wr_line[int'(beat_cnt)*WORD_SIZE +: WORD_SIZE] = ram_wdata;
        unique case (state)
            S_IDLE:   if (ram_avalid)
                          state_d = !ram_rnw ? S_WCAPT : (LATENCY > 0) ? S_RWAIT : S_RBURST;
            S_WCAPT:  if (last_beat) begin
                          mem_we  = 1'b1;
                          state_d = S_WACK;
                      end
            S_WACK:   state_d = S_IDLE;
            S_RWAIT:  if (lat_done) state_d = S_RBURST;
            S_RBURST: if (last_beat) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        ram_ack   = (state == S_WACK) || (state == S_RBURST);
        ram_rdata = (state == S_RBURST) ? data_backdoor[int'(beat_cnt)*WORD_SIZE +: WORD_SIZE] : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge ram_clk or negedge ram_rst_n) begin
        if (!ram_rst_n) begin
            addr_q        <= '0;
            line_q        <= '0;
            beat_cnt      <= '0;
            lat_cnt       <= '0;
            data_backdoor <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (ram_avalid) begin
                    addr_q <= ram_addr;
                    if (!ram_rnw) begin
                        line_q[WORD_SIZE-1:0] <= ram_wdata;
                        beat_cnt              <= BEAT_W'(1);
                    end
                end
                S_WCAPT: begin
                    line_q   <= wr_line;
                    beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                    if (last_beat) data_backdoor <= wr_line;
                end
                S_RWAIT:  lat_cnt  <= lat_done ? '0 : lat_cnt + 1'b1;
                S_RBURST: beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                default: ;
            endcase
            if (state != S_RBURST && state_d == S_RBURST) data_backdoor <= rd_line;
        end
    end

endmodule

// File: tb/tb_ram_line_responder.sv
// Directed self-checking bench for ram_line_responder: reset, write/read bursts,
// unwritten-line reads, reset abort of a write and back-to-back requests.
module tb_ram_line_responder;
    localparam int AW  = 13;
    localparam int WW  = 16;
    localparam int LW  = 64;
    localparam int LAT = 4;
    localparam int NB  = LW / WW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] ram_addr = '0;
    logic          ram_avalid = 1'b0;
    logic          ram_rnw = 1'b0;
    logic [WW-1:0] ram_wdata = '0;
    logic [WW-1:0] ram_rdata;
    logic          ram_ack;
    logic [LW-1:0] data_backdoor;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_line_responder #(
        .ADDR_SIZE (AW),
        .WORD_SIZE (WW),
        .LINE_WIDTH(LW),
        .LATENCY   (LAT)
    ) dut (
        .ram_clk      (clk),
        .ram_rst_n    (rst_n),
        .ram_addr     (ram_addr),
        .ram_avalid   (ram_avalid),
        .ram_rnw      (ram_rnw),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .ram_ack      (ram_ack),
        .data_backdoor(data_backdoor)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge in an IDLE cycle; returns at the falling edge of the next IDLE cycle.
    task automatic write_line(input logic [AW-1:0] a, input logic [LW-1:0] line);
        ram_avalid = 1'b1;
        ram_rnw    = 1'b0;
        ram_addr   = a;
        ram_wdata  = line[WW-1:0];
        check("wr_idle_ack", 64'(ram_ack), 64'd0);
        for (int k = 1; k < NB; k++) begin
            @(negedge clk);
            ram_avalid = 1'b0;
            ram_wdata  = line[k*WW +: WW];
            check("wr_capt_ack", 64'(ram_ack), 64'd0);
        end
        @(negedge clk);
        ram_wdata = '0;
        check("wr_ack", 64'(ram_ack), 64'd1);
        check("wr_backdoor", data_backdoor, line);
        @(negedge clk);
        check("wr_ack_single", 64'(ram_ack), 64'd0);
    endtask

    // poke pulses a write address phase in the middle of the burst; it must be ignored.
    task automatic read_line(input logic [AW-1:0] a, input logic [LW-1:0] exp,
                             input bit chk_data, input bit poke);
        ram_avalid = 1'b1;
        ram_rnw    = 1'b1;
        ram_addr   = a;
        check("rd_idle_ack", 64'(ram_ack), 64'd0);
        for (int c = 0; c < LAT; c++) begin
            @(negedge clk);
            ram_avalid = 1'b0;
            check("rd_wait_ack", 64'(ram_ack), 64'd0);
            check("rd_wait_rdata", 64'(ram_rdata), 64'd0);
        end
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            ram_avalid = poke && (k == 1);
            ram_rnw    = 1'b0;
            ram_wdata  = 16'hffff;
            check("rd_burst_ack", 64'(ram_ack), 64'd1);
            if (chk_data) begin
                check("rd_burst_data", 64'(ram_rdata), 64'(exp[k*WW +: WW]));
                if (k == 0) check("rd_backdoor", data_backdoor, exp);
            end
        end
        @(negedge clk);
        ram_avalid = 1'b0;
        ram_wdata  = '0;
        check("rd_end_ack", 64'(ram_ack), 64'd0);
        check("rd_end_rdata", 64'(ram_rdata), 64'd0);
    endtask

    localparam logic [LW-1:0] LINE_A   = 64'hdead_beef_1000_9bbc;
    localparam logic [LW-1:0] LINE_B   = 64'h1111_2222_3333_4444;
    localparam logic [LW-1:0] LINE_C   = 64'h0bad_cafe_5a5a_a5a5;
    localparam logic [LW-1:0] FILL_3   = 64'h000f_000e_000d_000c;
    localparam logic [LW-1:0] FILL_1   = 64'h0007_0006_0005_0004;
    localparam logic [LW-1:0] BEATS_X  = 64'h7777_6666_5555_abcd;

    initial begin
        bit fill_en;
`ifdef RAM_LINE_RESPONDER_FILL_EN
        fill_en = 1'b1;
`else
        fill_en = 1'b0;
`endif
        // 1: reset then idle
        repeat (2) @(negedge clk);
        check("rst_ack", 64'(ram_ack), 64'd0);
        check("rst_backdoor", data_backdoor, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ack", 64'(ram_ack), 64'd0);
            check("idle_rdata", 64'(ram_rdata), 64'd0);
            check("idle_backdoor", data_backdoor, 64'd0);
        end

        // 2 and 3: write then read 0x15E6
        write_line(13'h15e6, LINE_A);
        read_line(13'h15e6, LINE_A, 1'b1, 1'b0);

        // 4: never-written line
        read_line(13'h0003, FILL_3, fill_en, 1'b0);

        // 5: write aborted by reset after beat 2
        write_line(13'h0001, LINE_B);
        ram_avalid = 1'b1;
        ram_rnw    = 1'b0;
        ram_addr   = 13'h0001;
        ram_wdata  = BEATS_X[WW-1:0];
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            ram_avalid = 1'b0;
            ram_wdata  = BEATS_X[k*WW +: WW];
            check("abort_ack", 64'(ram_ack), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_rst_ack", 64'(ram_ack), 64'd0);
        check("abort_rst_rdata", 64'(ram_rdata), 64'd0);
        check("abort_rst_backdoor", data_backdoor, 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        ram_wdata = '0;
        check("abort_post_ack", 64'(ram_ack), 64'd0);
        @(negedge clk);
        check("abort_idle_ack", 64'(ram_ack), 64'd0);
        // Reset clears the written bitmap, so with fill enabled the line reads back as the pattern.
        read_line(13'h0001, fill_en ? FILL_1 : LINE_B, 1'b1, 1'b0);

        // 6: back-to-back write then read, with an ignored address phase mid-burst
        write_line(13'h0100, LINE_C);
        read_line(13'h0100, LINE_C, 1'b1, 1'b1);
        read_line(13'h0100, LINE_C, 1'b1, 1'b0);
        write_line(13'h15e6, LINE_B);
        read_line(13'h15e6, LINE_B, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
